// File: rtl/sprite_mem_pkg.sv
// Sprite memory bus controller shared definitions.
// Holds FSM state encoding, default bus widths and the turnaround length.
package sprite_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    // Cycles the shared bus is left undriven between a write and a read.
    localparam int TURN_LEN = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        TURN      = 3'd3,
        RD_ADDR   = 3'd4,
        RD_CAP    = 3'd5
    } state_t;

endpackage

// File: rtl/sprite_mem_bus_ctrl_if.sv
// Sprite memory bus: requester handshakes plus SRAM/tristate pins.
// slave = controller side, master = requester + SRAM/bus environment.
interface sprite_mem_bus_ctrl_if #(
    parameter int DATA_W = sprite_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = sprite_mem_pkg::ADDR_W_DEF
);

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_n;
    logic              mem_oe_n;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_din;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr, bus_din,
        output wr_ack, rd_ack, rd_valid, rd_data,
        output mem_addr, mem_we_n, mem_oe_n,
        output bus_dout, bus_oe
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr, bus_din,
        input  wr_ack, rd_ack, rd_valid, rd_data,
        input  mem_addr, mem_we_n, mem_oe_n,
        input  bus_dout, bus_oe
    );

endinterface

// File: rtl/sprite_mem_arb.sv
// Read/write arbiter: reads win unless the write has lost 3 times
// (fairness only with SPRITEMEM_WR_FAIRNESS_EN defined). Grants only when idle.
module sprite_mem_arb (
`ifdef SPRITEMEM_WR_FAIRNESS_EN
    input  logic clock,
    input  logic resetn,
`endif
    input  logic idle,
    input  logic wr_req,
    input  logic rd_req,
    output logic grant_rd,
    output logic grant_wr
);

    logic w_win;

`ifdef SPRITEMEM_WR_FAIRNESS_EN
    logic [1:0] lost_cnt;

    assign w_win = wr_req && (!rd_req || (lost_cnt == 2'd3));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lost_cnt <= 2'd0;
        end else if (grant_wr) begin
            lost_cnt <= 2'd0;
        end else if (grant_rd && wr_req) begin
            lost_cnt <= lost_cnt + 2'd1;
        end
    end
`else
    assign w_win = wr_req && !rd_req;
`endif

    assign grant_wr = idle && w_win;
    assign grant_rd = idle && rd_req && !w_win;

endmodule

// File: rtl/sprite_mem_bus_ctrl.sv
// Sprite SRAM bus controller: serialises writes and reads onto a shared
// tristate bus. Ports: clock, resetn, bus (slave). Option: SPRITEMEM_WR_FAIRNESS_EN.
module sprite_mem_bus_ctrl #(
    parameter int DATA_W = sprite_mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = sprite_mem_pkg::ADDR_W_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    sprite_mem_bus_ctrl_if.slave bus
);

    import sprite_mem_pkg::*;

    state_t            state;
    state_t            nxt;
    logic              idle;
    logic              grant_rd;
    logic              grant_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // Gated by resetn so nothing is acknowledged while reset is held.
    assign idle = (state == IDLE) && resetn;

    sprite_mem_arb u_arb (
`ifdef SPRITEMEM_WR_FAIRNESS_EN
        .clock    (clock),
        .resetn   (resetn),
`endif
        .idle     (idle),
        .wr_req   (bus.wr_req),
        .rd_req   (bus.rd_req),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_rd) begin
                    nxt = RD_ADDR;
                end else if (grant_wr) begin
                    nxt = WR_SETUP;
                end
            end
            WR_SETUP:  nxt = WR_STROBE;
            WR_STROBE: nxt = TURN;
            TURN:      nxt = IDLE;
            RD_ADDR:   nxt = RD_CAP;
            RD_CAP:    nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_oe   = 1'b0;
        bus.mem_we_n = 1'b1;
        bus.mem_oe_n = 1'b1;
        unique case (state)
            WR_SETUP: begin
                bus.bus_oe = 1'b1;
            end
            WR_STROBE: begin
                bus.bus_oe   = 1'b1;
                bus.mem_we_n = 1'b0;
            end
            RD_ADDR, RD_CAP: begin
                bus.mem_oe_n = 1'b0;
            end
            default: begin
                bus.bus_oe = 1'b0;
            end
        endcase
    end

    assign bus.wr_ack   = grant_wr;
    assign bus.rd_ack   = grant_rd;
    assign bus.rd_valid = rvalid_q;
    assign bus.rd_data  = rdata_q;
    assign bus.mem_addr = addr_q;
    assign bus.bus_dout = dout_q;

    // One address register serves both directions; only one is in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (grant_rd) begin
                addr_q <= bus.rd_addr;
            end else if (grant_wr) begin
                addr_q <= bus.wr_addr;
                dout_q <= bus.wr_data;
            end
            rvalid_q <= (state == RD_CAP);
            if (state == RD_CAP) begin
                rdata_q <= bus.bus_din;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_bus_ctrl.sv
// Self-checking bench for sprite_mem_bus_ctrl with a behavioural SRAM
// and a transaction-level reference memory.
module tb_sprite_mem_bus_ctrl;

    localparam int DW = 16;
    localparam int AW = 12;

    logic clock;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] written [$];

    sprite_mem_bus_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sprite_mem_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment: SRAM drives the bus when its output enable is low.
    assign bus.bus_din = (bus.mem_oe_n == 1'b0) ? sram[bus.mem_addr] : 16'h5A5A;

    always @(negedge clock) begin
        if (bus.mem_we_n === 1'b0 && bus.bus_oe === 1'b1)
            sram[bus.mem_addr] = bus.bus_dout;
    end

    // Bus contention monitor over the whole run.
    always @(negedge clock) begin
        checks++;
        if (bus.bus_oe === 1'b1 && bus.mem_oe_n === 1'b0) begin
            errors++;
            $display("FAIL contention t=%0t bus_oe=%b mem_oe_n=%b required not both active",
                     $time, bus.bus_oe, bus.mem_oe_n);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        resetn = 1'b0;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.wr_addr = 12'h3FF;
        bus.rd_addr = 12'h155;
        bus.wr_data = 16'hFFFF;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.wr_ack !== 1'b0 || bus.rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: wr_ack=%b rd_ack=%b required 0 0", bus.wr_ack, bus.rd_ack);
        end
        checks++;
        if (bus.bus_oe !== 1'b0 || bus.mem_we_n !== 1'b1 || bus.mem_oe_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_pins: oe=%b we_n=%b oe_n=%b required 0 1 1",
                     bus.bus_oe, bus.mem_we_n, bus.mem_oe_n);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0 ||
            bus.mem_addr !== 12'h0 || bus.bus_dout !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: rv=%b rd=%h ma=%h bd=%h required 0 0 0 0",
                     bus.rd_valid, bus.rd_data, bus.mem_addr, bus.bus_dout);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_write();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int w;
            a = (t == 0) ? 12'h012 : AW'($urandom_range(0, 4095));
            if (t != 0 && a == 12'h012) a = 12'h013;
            d = (t == 0) ? 16'hBEEF : DW'($urandom);
            @(posedge clock);
            #1;
            bus.wr_req = 1'b1;
            bus.wr_addr = a;
            bus.wr_data = d;
            w = 0;
            @(negedge clock);
            while (bus.wr_ack !== 1'b1 && w < 16) begin
                @(negedge clock);
                w++;
            end
            checks++;
            if (bus.wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL write_ack: wr_ack=%b required 1 within 16 cycles", bus.wr_ack);
            end
            @(posedge clock);
            #1;
            bus.wr_req = 1'b0;
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
            for (int off = 1; off <= 4; off++) begin
                logic e_oe;
                logic e_we_n;
                @(negedge clock);
                e_oe = (off == 1 || off == 2);
                e_we_n = (off != 2);
                checks++;
                if (bus.bus_oe !== e_oe) begin
                    errors++;
                    $display("FAIL write_oe n+%0d: bus_oe=%b required %b", off, bus.bus_oe, e_oe);
                end
                checks++;
                if (bus.mem_we_n !== e_we_n || bus.mem_oe_n !== 1'b1) begin
                    errors++;
                    $display("FAIL write_we n+%0d: we_n=%b oe_n=%b required %b 1",
                             off, bus.mem_we_n, bus.mem_oe_n, e_we_n);
                end
                if (e_oe) begin
                    checks++;
                    if (bus.bus_dout !== d || bus.mem_addr !== a) begin
                        errors++;
                        $display("FAIL write_data n+%0d: dout=%h addr=%h required %h %h",
                                 off, bus.bus_dout, bus.mem_addr, d, a);
                    end
                end
            end
            ref_mem[a] = d;
            written.push_back(a);
        end
    endtask

    task automatic test_read();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] e;
            int w;
            if (t == 0) a = 12'h012;
            else if (t < 4) a = written[$urandom_range(0, written.size() - 1)];
            else a = AW'($urandom_range(0, 4095));
            e = ref_mem[a];
            @(posedge clock);
            #1;
            bus.rd_req = 1'b1;
            bus.rd_addr = a;
            w = 0;
            @(negedge clock);
            while (bus.rd_ack !== 1'b1 && w < 16) begin
                @(negedge clock);
                w++;
            end
            checks++;
            if (bus.rd_ack !== 1'b1) begin
                errors++;
                $display("FAIL read_ack: rd_ack=%b required 1 within 16 cycles", bus.rd_ack);
            end
            @(posedge clock);
            #1;
            bus.rd_req = 1'b0;
            bus.rd_addr = AW'($urandom);
            for (int off = 1; off <= 4; off++) begin
                @(negedge clock);
                checks++;
                if (bus.mem_oe_n !== (off >= 3) || bus.bus_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL read_oe n+%0d: oe_n=%b bus_oe=%b required %b 0",
                             off, bus.mem_oe_n, bus.bus_oe, off >= 3);
                end
                if (off <= 2) begin
                    checks++;
                    if (bus.mem_addr !== a) begin
                        errors++;
                        $display("FAIL read_addr n+%0d: addr=%h required %h", off, bus.mem_addr, a);
                    end
                end
                checks++;
                if (bus.rd_valid !== (off == 3)) begin
                    errors++;
                    $display("FAIL read_valid n+%0d: rd_valid=%b required %b",
                             off, bus.rd_valid, off == 3);
                end
                if (off >= 3) begin
                    checks++;
                    if (bus.rd_data !== e) begin
                        errors++;
                        $display("FAIL read_data n+%0d addr=%h: rd_data=%h required %h",
                                 off, a, bus.rd_data, e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int w;
        a = AW'($urandom_range(0, 4095));
        d = DW'($urandom);
        @(posedge clock);
        #1;
        bus.wr_req = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        w = 0;
        @(negedge clock);
        while (bus.wr_ack !== 1'b1 && w < 16) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (bus.wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wr_ack: wr_ack=%b required 1", bus.wr_ack);
        end
        @(posedge clock);
        #1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_addr = a;
        for (int off = 1; off <= 4; off++) begin
            @(negedge clock);
            checks++;
            if (bus.rd_ack !== (off == 4)) begin
                errors++;
                $display("FAIL b2b_rd_ack n+%0d: rd_ack=%b required %b", off, bus.rd_ack, off == 4);
            end
            if (off == 3) begin
                checks++;
                if (bus.bus_oe !== 1'b0 || bus.mem_we_n !== 1'b1 || bus.mem_oe_n !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_turn: oe=%b we_n=%b oe_n=%b required 0 1 1",
                             bus.bus_oe, bus.mem_we_n, bus.mem_oe_n);
                end
            end
        end
        @(posedge clock);
        #1;
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clock);
        ref_mem[a] = d;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== d) begin
            errors++;
            $display("FAIL b2b_read_back: rd_valid=%b rd_data=%h required 1 %h",
                     bus.rd_valid, bus.rd_data, d);
        end
    endtask

    task automatic test_arbitration();
        int  nrd = 0;
        int  rd_before = -1;
        bit  wr_done = 0;
        int  w;
        @(posedge clock);
        #1;
        bus.wr_req = 1'b1;
        bus.wr_addr = AW'($urandom);
        bus.wr_data = DW'($urandom);
        bus.rd_req = 1'b1;
        bus.rd_addr = AW'($urandom);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++;
            if (bus.rd_ack === 1'b1 && bus.wr_ack === 1'b1) begin
                errors++;
                $display("FAIL arb_both_ack: cycle %0d both acks high", i);
            end
            if (bus.wr_ack === 1'b1 && !wr_done) begin
                wr_done = 1;
                rd_before = nrd;
            end
            if (bus.rd_ack === 1'b1) nrd++;
            @(posedge clock);
            #1;
            if (wr_done) bus.wr_req = 1'b0;
            bus.rd_addr = AW'($urandom);
        end
        bus.rd_req = 1'b0;
        checks++;
`ifdef SPRITEMEM_WR_FAIRNESS_EN
        if (!wr_done || rd_before != 3) begin
            errors++;
            $display("FAIL arb_fair: wr granted=%0d after %0d reads required 1 after 3",
                     wr_done, rd_before);
        end
`else
        if (wr_done || nrd < 8) begin
            errors++;
            $display("FAIL arb_strict: wr granted=%0d reads=%0d required 0 and >=8",
                     wr_done, nrd);
        end
`endif
        if (!wr_done) begin
            w = 0;
            @(negedge clock);
            while (bus.wr_ack !== 1'b1 && w < 10) begin
                @(negedge clock);
                w++;
            end
            checks++;
            if (bus.wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL arb_pending: wr_ack=%b required 1 once rd_req drops", bus.wr_ack);
            end
            @(posedge clock);
            #1;
            bus.wr_req = 1'b0;
        end
        repeat (6) @(posedge clock);
    endtask

    task automatic test_reset_mid_write();
        int w;
        @(posedge clock);
        #1;
        bus.wr_req = 1'b1;
        bus.wr_addr = 12'hFFE;
        bus.wr_data = DW'($urandom);
        w = 0;
        @(negedge clock);
        while (bus.wr_ack !== 1'b1 && w < 16) begin
            @(negedge clock);
            w++;
        end
        @(posedge clock);
        #1;
        bus.wr_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.mem_we_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_strobe: mem_we_n=%b required 0 before reset", bus.mem_we_n);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (bus.mem_we_n !== 1'b1 || bus.bus_oe !== 1'b0 || bus.mem_oe_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pins: we_n=%b oe=%b oe_n=%b required 1 0 1",
                     bus.mem_we_n, bus.bus_oe, bus.mem_oe_n);
        end
        checks++;
        if (bus.mem_addr !== 12'h0 || bus.bus_dout !== 16'h0 || bus.rd_data !== 16'h0 ||
            bus.rd_valid !== 1'b0 || bus.wr_ack !== 1'b0 || bus.rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_regs: ma=%h bd=%h rd=%h rv=%b wa=%b ra=%b required all 0",
                     bus.mem_addr, bus.bus_dout, bus.rd_data, bus.rd_valid,
                     bus.wr_ack, bus.rd_ack);
        end
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (bus.bus_oe !== 1'b0 || bus.mem_we_n !== 1'b1 || bus.mem_oe_n !== 1'b1 ||
                bus.rd_valid !== 1'b0 || bus.mem_addr !== 12'h0) begin
                errors++;
                $display("FAIL rst_no_resume c%0d: oe=%b we_n=%b oe_n=%b rv=%b ma=%h required 0 1 1 0 0",
                         i, bus.bus_oe, bus.mem_we_n, bus.mem_oe_n, bus.rd_valid, bus.mem_addr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            sram[i] = v;
            ref_mem[i] = v;
        end
        resetn = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_arbitration();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_mem_bus_ctrl.md
SPRITE_MEM_BUS_CTRL -- requirements
Module: sprite_mem_bus_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of the sprite memory data bus.
REQ-002 Parameter ADDR_W, default 12, SHALL set the width of the sprite memory address.
REQ-003 clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 wr_req  input  1  SHALL request a write; wr_addr  input  ADDR_W; wr_data  input  DATA_W.
REQ-006 wr_ack  output  1  SHALL pulse for one cycle when a write is accepted.
REQ-007 rd_req  input  1  SHALL request a read; rd_addr  input  ADDR_W.
REQ-008 rd_ack  output  1  SHALL pulse for one cycle on read acceptance; rd_valid  output  1  SHALL pulse when rd_data  output  DATA_W  is valid.
REQ-009 mem_addr  output  ADDR_W; mem_we_n  output  1; mem_oe_n  output  1  SHALL drive the SRAM control pins, active-low.
REQ-010 bus_dout  output  DATA_W and bus_oe  output  1 SHALL feed the external N-bit tristate driver; bus_din  input  DATA_W  SHALL be the resolved shared bus.

Function
REQ-011 FSM states SHALL be IDLE, WR_SETUP, WR_STROBE, TURN, RD_ADDR, RD_CAP.
REQ-012 In IDLE, when rd_req=1, the controller SHALL accept the read (rd_ack=1, latch rd_addr) and go to RD_ADDR; otherwise, when wr_req=1, it SHALL accept the write (wr_ack=1, latch wr_addr/wr_data) and go to WR_SETUP.
REQ-013 Requests SHALL be sampled only in IDLE; requesters hold req until ack; inputs outside acceptance are ignored.
REQ-014 WR_SETUP: bus_oe=1, mem_addr/bus_dout = latched values, mem_we_n=1; next WR_STROBE.
REQ-015 WR_STROBE: bus_oe=1, mem_we_n=0; next TURN.
REQ-016 TURN: bus_oe=0, mem_we_n=1, mem_oe_n=1 for exactly one cycle; next IDLE.
REQ-017 RD_ADDR: mem_oe_n=0, bus_oe=0, mem_addr = latched rd_addr; next RD_CAP.
REQ-018 RD_CAP: mem_oe_n=0; rd_data SHALL register bus_din at the end of the cycle; next IDLE, with rd_valid=1 for that one IDLE cycle.
REQ-019 Latency: a write accepted in cycle n SHALL strobe in n+2 and return to IDLE at n+4; a read accepted in cycle n SHALL give rd_valid=1 in n+3.
REQ-020 bus_oe=1 and mem_oe_n=0 SHALL never coincide; every write SHALL be followed by TURN before any read.
REQ-021 rd_req and wr_req both high in IDLE SHALL resolve per REQ-012 unless REQ-026 applies; the losing request stays pending.
REQ-022 rd_data SHALL hold its value until the next RD_CAP.

Reset
REQ-023 resetn=0 SHALL immediately force IDLE, bus_oe=0, mem_we_n=1, mem_oe_n=1, wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0, mem_addr=0, bus_dout=0, and clear the fairness counter.
REQ-024 Reset asserted mid-write SHALL abort the write with mem_we_n=1 immediately; no transaction resumes after release.
REQ-025 The first acceptance SHALL occur no earlier than the first rising edge after resetn deasserts.

Configuration
REQ-026 With SPRITEMEM_WR_FAIRNESS_EN defined, a 2-bit counter SHALL count IDLE cycles in which wr_req lost to rd_req; at count 3 the next IDLE with wr_req=1 SHALL grant the write, clearing the counter; any write grant clears it.
REQ-027 Without SPRITEMEM_WR_FAIRNESS_EN, reads SHALL have strict priority, and no counter SHALL be synthesized.

Structure
REQ-028 Package sprite_mem_pkg SHALL hold the state encoding, default DATA_W/ADDR_W, and the TURN length constant (1).
REQ-029 Arbitration (priority plus fairness counter) SHALL live in sub-module sprite_mem_arb; the FSM and datapath SHALL stay in sprite_mem_bus_ctrl.

Verification
REQ-030 Reset, then a write of 0xBEEF to address 0x012 -> wr_ack in n, bus_oe=1 in n+1..n+2, mem_we_n=0 only in n+2, bus_dout=0xBEEF, IDLE at n+4.
REQ-031 Read of 0x012 with bus_din=0xBEEF -> rd_ack in n, mem_oe_n=0 in n+1..n+2, rd_valid=1 and rd_data=0xBEEF in n+3.
REQ-032 Write immediately followed by a read -> TURN cycle present, and bus_oe and !mem_oe_n never both high (assertion over the whole run).
REQ-033 rd_req and wr_req held high together -> read first; with SPRITEMEM_WR_FAIRNESS_EN, the write is granted after 3 lost IDLE cycles; without it, the write is starved while rd_req stays high.
REQ-034 resetn pulsed low during WR_STROBE -> mem_we_n=1 and bus_oe=0 before the next edge; the FSM is in IDLE and all outputs are at reset values.
